// File: rtl/lagarto_fp_mult_norm_round.sv
// Normalize and round stage after the FP mantissa multiplier.
// Takes the 2*MANTISSA-bit product with precomputed sign/exponent and returns
// the packed-ready sign, exponent field and fraction plus overflow/underflow/
// inexact flags. Default build: two registered stages (latency 2).
// Define LAGARTO_FP_NR_ONE_STAGE_EN to drop the normalize register, so
// normalize and round feed one register (latency 1).
module lagarto_fp_mult_norm_round #(
  parameter int MANTISSA = 53,
  parameter int EXPONENT = 11
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    lock_i,
  input  logic                    flush_i,
  input  logic                    op_valid_i,
  input  logic [2*MANTISSA-1:0]   product_i,
  input  logic [EXPONENT+1:0]     exp_i,
  input  logic                    sign_i,
  input  logic [2:0]              rm_i,
  output logic                    result_valid_o,
  output logic                    sign_o,
  output logic [EXPONENT-1:0]     exp_o,
  output logic [MANTISSA-2:0]     mant_o,
  output logic                    overflow_o,
  output logic                    underflow_o,
  output logic                    inexact_o
);

  localparam int PW  = 2 * MANTISSA;
  // Internal exponent is wide enough for exp_i minus a full-width left shift.
  localparam int EXW = EXPONENT + 3 + $clog2(PW);
  localparam int LZW = $clog2(PW + 1);
  localparam int SHW = $clog2(PW + 2);

  logic [EXW-1:0] exp_ext;
  logic [LZW-1:0] lzc;
  logic [EXW-1:0] lzc_ext;
  logic [PW-2:0]  n1_mant;
  logic           n1_sticky;
  logic [EXW-1:0] n1_exp;
  logic [EXW-1:0] sh_full;
  logic [SHW-1:0] sh_amt;
  logic [2*PW-3:0] ext;

  assign exp_ext = {{(EXW-EXPONENT-2){exp_i[EXPONENT+1]}}, exp_i};
  assign lzc_ext = {{(EXW-LZW){1'b0}}, lzc};

  // Leading-zero count of the product (last hit is the highest set bit).
  always_comb begin
    lzc = LZW'(PW);
    for (int i = 0; i < PW; i++) begin
      if (product_i[i]) lzc = LZW'(PW - 1 - i);
    end
  end

  // Normalize: hidden bit lands at PW-2; exponents <= 0 denormalize into sticky.
  always_comb begin
    n1_mant   = '0;
    n1_sticky = 1'b0;
    n1_exp    = '0;
    sh_full   = '0;
    sh_amt    = '0;
    ext       = '0;
    if (product_i[PW-1]) begin
      n1_mant   = product_i[PW-1:1];
      n1_sticky = product_i[0];
      n1_exp    = exp_ext + EXW'(1);
    end else if (product_i[PW-2]) begin
      n1_mant = product_i[PW-2:0];
      n1_exp  = exp_ext;
    end else if (|product_i) begin
      n1_mant = product_i[PW-2:0] << (lzc - LZW'(1));
      n1_exp  = exp_ext - lzc_ext + EXW'(1);
    end
    if ((|product_i) && (n1_exp[EXW-1] || (n1_exp == '0))) begin
      sh_full   = EXW'(1) - n1_exp;
      sh_amt    = (sh_full > EXW'(PW + 1)) ? SHW'(PW + 1) : sh_full[SHW-1:0];
      ext       = {n1_mant, {(PW-1){1'b0}}} >> sh_amt;
      n1_mant   = ext[2*PW-3:PW-1];
      n1_sticky = n1_sticky | (|ext[PW-2:0]);
      n1_exp    = '0;
    end
  end

  logic           r_valid;
  logic           r_sign;
  logic [2:0]     r_rm;
  logic [EXW-1:0] r_exp;
  logic [PW-2:0]  r_mant;
  logic           r_sticky;

`ifdef LAGARTO_FP_NR_ONE_STAGE_EN
  assign r_valid  = op_valid_i;
  assign r_sign   = sign_i;
  assign r_rm     = rm_i;
  assign r_exp    = n1_exp;
  assign r_mant   = n1_mant;
  assign r_sticky = n1_sticky;
`else
  logic           s1_valid_q, s1_valid_d;
  logic           s1_sign_q, s1_sign_d;
  logic [2:0]     s1_rm_q, s1_rm_d;
  logic [EXW-1:0] s1_exp_q, s1_exp_d;
  logic [PW-2:0]  s1_mant_q, s1_mant_d;
  logic           s1_sticky_q, s1_sticky_d;

  // Stage-1 next state: flush clears, lock holds, otherwise capture.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sign_d   = s1_sign_q;
    s1_rm_d     = s1_rm_q;
    s1_exp_d    = s1_exp_q;
    s1_mant_d   = s1_mant_q;
    s1_sticky_d = s1_sticky_q;
    if (flush_i) begin
      s1_valid_d  = 1'b0;
      s1_sign_d   = 1'b0;
      s1_rm_d     = '0;
      s1_exp_d    = '0;
      s1_mant_d   = '0;
      s1_sticky_d = 1'b0;
    end else if (!lock_i) begin
      s1_valid_d  = op_valid_i;
      s1_sign_d   = sign_i;
      s1_rm_d     = rm_i;
      s1_exp_d    = n1_exp;
      s1_mant_d   = n1_mant;
      s1_sticky_d = n1_sticky;
    end
  end

  // Stage-1 register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_rm_q     <= '0;
      s1_exp_q    <= '0;
      s1_mant_q   <= '0;
      s1_sticky_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_rm_q     <= s1_rm_d;
      s1_exp_q    <= s1_exp_d;
      s1_mant_q   <= s1_mant_d;
      s1_sticky_q <= s1_sticky_d;
    end
  end

  assign r_valid  = s1_valid_q;
  assign r_sign   = s1_sign_q;
  assign r_rm     = s1_rm_q;
  assign r_exp    = s1_exp_q;
  assign r_mant   = s1_mant_q;
  assign r_sticky = s1_sticky_q;
`endif

  logic [MANTISSA-1:0] top;
  logic                guard;
  logic                st;
  logic                inc;
  logic [MANTISSA:0]   sum;
  logic [MANTISSA-1:0] mant_r;
  logic [EXW-1:0]      exp_r;
  logic                to_inf;
  logic                rnd_ovf, rnd_udf, rnd_inx;
  logic [EXPONENT-1:0] rnd_exp;
  logic [MANTISSA-2:0] rnd_mant;

  // Round to M bits per rounding mode, then resolve carry, subnormal promotion, overflow.
  always_comb begin
    top   = r_mant[PW-2 -: MANTISSA];
    guard = r_mant[MANTISSA-2];
    st    = (|r_mant[MANTISSA-3:0]) | r_sticky;
    case (r_rm)
      3'b001:  inc = 1'b0;
      3'b010:  inc = r_sign & (guard | st);
      3'b011:  inc = ~r_sign & (guard | st);
      3'b100:  inc = guard;
      default: inc = guard & (st | top[0]);
    endcase
    sum    = {1'b0, top} + {{MANTISSA{1'b0}}, inc};
    exp_r  = r_exp;
    mant_r = sum[MANTISSA-1:0];
    if (sum[MANTISSA]) begin
      mant_r = sum[MANTISSA:1];
      exp_r  = r_exp + EXW'(1);
    end else if ((r_exp == '0) && sum[MANTISSA-1]) begin
      exp_r = EXW'(1);
    end
    rnd_inx  = guard | st;
    rnd_ovf  = exp_r >= EXW'((1 << EXPONENT) - 1);
    rnd_exp  = exp_r[EXPONENT-1:0];
    rnd_mant = mant_r[MANTISSA-2:0];
    to_inf   = 1'b0;
    if (rnd_ovf) begin
      rnd_inx = 1'b1;
      case (r_rm)
        3'b001:  to_inf = 1'b0;
        3'b010:  to_inf = r_sign;
        3'b011:  to_inf = ~r_sign;
        default: to_inf = 1'b1;
      endcase
      if (to_inf) begin
        rnd_exp  = '1;
        rnd_mant = '0;
      end else begin
        rnd_exp  = EXPONENT'((1 << EXPONENT) - 2);
        rnd_mant = '1;
      end
    end
    rnd_udf = (r_exp == '0) & rnd_inx;
  end

  logic                res_valid_q, res_valid_d;
  logic                res_sign_q, res_sign_d;
  logic [EXPONENT-1:0] res_exp_q, res_exp_d;
  logic [MANTISSA-2:0] res_mant_q, res_mant_d;
  logic                res_ovf_q, res_ovf_d;
  logic                res_udf_q, res_udf_d;
  logic                res_inx_q, res_inx_d;

  // Output stage next state: flush clears, lock holds, invalid slots carry zeros.
  always_comb begin
    res_valid_d = res_valid_q;
    res_sign_d  = res_sign_q;
    res_exp_d   = res_exp_q;
    res_mant_d  = res_mant_q;
    res_ovf_d   = res_ovf_q;
    res_udf_d   = res_udf_q;
    res_inx_d   = res_inx_q;
    if (flush_i) begin
      res_valid_d = 1'b0;
      res_sign_d  = 1'b0;
      res_exp_d   = '0;
      res_mant_d  = '0;
      res_ovf_d   = 1'b0;
      res_udf_d   = 1'b0;
      res_inx_d   = 1'b0;
    end else if (!lock_i) begin
      res_valid_d = r_valid;
      res_sign_d  = r_valid & r_sign;
      res_exp_d   = r_valid ? rnd_exp : '0;
      res_mant_d  = r_valid ? rnd_mant : '0;
      res_ovf_d   = r_valid & rnd_ovf;
      res_udf_d   = r_valid & rnd_udf;
      res_inx_d   = r_valid & rnd_inx;
    end
  end

  // Output register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      res_valid_q <= 1'b0;
      res_sign_q  <= 1'b0;
      res_exp_q   <= '0;
      res_mant_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_udf_q   <= 1'b0;
      res_inx_q   <= 1'b0;
    end else begin
      res_valid_q <= res_valid_d;
      res_sign_q  <= res_sign_d;
      res_exp_q   <= res_exp_d;
      res_mant_q  <= res_mant_d;
      res_ovf_q   <= res_ovf_d;
      res_udf_q   <= res_udf_d;
      res_inx_q   <= res_inx_d;
    end
  end

  assign result_valid_o = res_valid_q;
  assign sign_o         = res_sign_q;
  assign exp_o          = res_exp_q;
  assign mant_o         = res_mant_q;
  assign overflow_o     = res_ovf_q;
  assign underflow_o    = res_udf_q;
  assign inexact_o      = res_inx_q;

endmodule

// File: tb/tb_lagarto_fp_mult_norm_round.sv
// Bench for lagarto_fp_mult_norm_round at single precision (M=24, E=8).
module tb_lagarto_fp_mult_norm_round;

  localparam int M   = 24;
  localparam int E   = 8;
  localparam int LAT = 2;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          lock_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          op_valid_i = 1'b0;
  logic [2*M-1:0] product_i = '0;
  logic [E+1:0]  exp_i = '0;
  logic          sign_i = 1'b0;
  logic [2:0]    rm_i = '0;
  logic          result_valid_o;
  logic          sign_o;
  logic [E-1:0]  exp_o;
  logic [M-2:0]  mant_o;
  logic          overflow_o;
  logic          underflow_o;
  logic          inexact_o;

  lagarto_fp_mult_norm_round #(.MANTISSA(M), .EXPONENT(E)) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .lock_i         (lock_i),
    .flush_i        (flush_i),
    .op_valid_i     (op_valid_i),
    .product_i      (product_i),
    .exp_i          (exp_i),
    .sign_i         (sign_i),
    .rm_i           (rm_i),
    .result_valid_o (result_valid_o),
    .sign_o         (sign_o),
    .exp_o          (exp_o),
    .mant_o         (mant_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o),
    .inexact_o      (inexact_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // res packs {sign, exp[7:0], frac[22:0], ovf, udf, inx}
  typedef struct {
    logic [47:0] p;
    logic [9:0]  e;
    logic        s;
    logic [2:0]  rm;
    logic [34:0] res;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  int          iss_q[$];
  logic        mon_en = 1'b0;
  vec_t        vecs[18];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] obs_word();
    return 64'({result_valid_o, sign_o, exp_o, mant_o, overflow_o, underflow_o, inexact_o});
  endfunction

  function automatic logic [63:0] want(input vec_t v);
    return 64'({1'b1, v.res});
  endfunction

  function automatic vec_t mk(input logic [47:0] p, input logic [9:0] e, input logic s,
                              input logic [2:0] rm, input logic rs, input logic [7:0] re,
                              input logic [22:0] rmant, input logic ov, input logic uf,
                              input logic nx);
    vec_t v;
    v.p   = p;
    v.e   = e;
    v.s   = s;
    v.rm  = rm;
    v.res = {rs, re, rmant, ov, uf, nx};
    return v;
  endfunction

  task automatic drive_op(input vec_t v);
    op_valid_i = 1'b1;
    product_i  = v.p;
    exp_i      = v.e;
    sign_i     = v.s;
    rm_i       = v.rm;
  endtask

  task automatic idle();
    op_valid_i = 1'b0;
    product_i  = '0;
    exp_i      = '0;
    sign_i     = 1'b0;
    rm_i       = '0;
  endtask

  // Scoreboard: each visible result pops the oldest expectation; idle slots must be all zero.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (result_valid_o) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_result", obs_word(), 64'd0);
        end else begin
          check_eq("result", obs_word(), exp_q.pop_front());
          check_eq("latency", 64'(cyc - iss_q.pop_front()), 64'(LAT));
        end
      end else begin
        check_eq("idle_gate", obs_word(), 64'd0);
      end
    end
  end

  initial begin
    vecs[0]  = mk(48'h900000000000, 10'd127, 1'b0, 3'd0, 1'b0, 8'h80, 23'h100000, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(48'h400000400000, 10'd100, 1'b0, 3'd0, 1'b0, 8'h64, 23'h000000, 1'b0, 1'b0, 1'b1);
    vecs[2]  = mk(48'h400000400000, 10'd100, 1'b0, 3'd3, 1'b0, 8'h64, 23'h000001, 1'b0, 1'b0, 1'b1);
    vecs[3]  = mk(48'h400000400000, 10'd100, 1'b0, 3'd4, 1'b0, 8'h64, 23'h000001, 1'b0, 1'b0, 1'b1);
    vecs[4]  = mk(48'h400000400000, 10'd100, 1'b0, 3'd2, 1'b0, 8'h64, 23'h000000, 1'b0, 1'b0, 1'b1);
    vecs[5]  = mk(48'h7FFFFFC00000, 10'd100, 1'b0, 3'd0, 1'b0, 8'h65, 23'h000000, 1'b0, 1'b0, 1'b1);
    vecs[6]  = mk(48'h900000000000, 10'd254, 1'b0, 3'd0, 1'b0, 8'hFF, 23'h000000, 1'b1, 1'b0, 1'b1);
    vecs[7]  = mk(48'h900000000000, 10'd254, 1'b0, 3'd1, 1'b0, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0, 1'b1);
    vecs[8]  = mk(48'h400000000000, 10'h3FE, 1'b0, 3'd0, 1'b0, 8'h00, 23'h100000, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(48'h400000000001, 10'h3FE, 1'b0, 3'd0, 1'b0, 8'h00, 23'h100000, 1'b0, 1'b1, 1'b1);
    vecs[10] = mk(48'h100000000000, 10'd100, 1'b1, 3'd0, 1'b1, 8'h62, 23'h000000, 1'b0, 1'b0, 1'b0);
    vecs[11] = mk(48'h000000000000, 10'd77,  1'b1, 3'd0, 1'b1, 8'h00, 23'h000000, 1'b0, 1'b0, 1'b0);
    vecs[12] = mk(48'h400000400000, 10'd100, 1'b1, 3'd2, 1'b1, 8'h64, 23'h000001, 1'b0, 1'b0, 1'b1);
    vecs[13] = mk(48'h900000000000, 10'd254, 1'b1, 3'd2, 1'b1, 8'hFF, 23'h000000, 1'b1, 1'b0, 1'b1);
    vecs[14] = mk(48'h400000C00000, 10'd100, 1'b0, 3'd5, 1'b0, 8'h64, 23'h000002, 1'b0, 1'b0, 1'b1);
    vecs[15] = mk(48'h7FFFFFC00000, 10'd0,   1'b0, 3'd0, 1'b0, 8'h01, 23'h000000, 1'b0, 1'b1, 1'b1);
    vecs[16] = mk(48'h400000000000, 10'h39C, 1'b0, 3'd3, 1'b0, 8'h00, 23'h000001, 1'b0, 1'b1, 1'b1);
    vecs[17] = mk(48'h900000000000, 10'd254, 1'b1, 3'd3, 1'b1, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0, 1'b1);

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("reset_outputs", obs_word(), 64'd0);
    rstn_i = 1'b1;

    // Back-to-back stream through the scoreboard
    mon_en = 1'b1;
    foreach (vecs[i]) begin
      @(posedge clk_i);
      #1;
      drive_op(vecs[i]);
      exp_q.push_back(want(vecs[i]));
      iss_q.push_back(cyc);
    end
    @(posedge clk_i);
    #1;
    idle();
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk_i);
    #1;
    mon_en = 1'b0;

    // Lock for 3 cycles with two ops in flight
    @(posedge clk_i); #1; drive_op(vecs[0]);
    @(posedge clk_i); #1; drive_op(vecs[6]);
    @(posedge clk_i); #1; idle(); lock_i = 1'b1;
    @(negedge clk_i);
    check_eq("lock_first", obs_word(), want(vecs[0]));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      check_eq("lock_hold", obs_word(), want(vecs[0]));
    end
    lock_i = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    check_eq("lock_second", obs_word(), want(vecs[6]));
    @(posedge clk_i); @(negedge clk_i);
    check_eq("lock_after", obs_word(), 64'd0);

    // Flush kills both in-flight slots
    @(posedge clk_i); #1; drive_op(vecs[1]);
    @(posedge clk_i); #1; drive_op(vecs[5]);
    @(posedge clk_i); #1; idle(); flush_i = 1'b1;
    @(negedge clk_i);
    check_eq("flush_pre", obs_word(), want(vecs[1]));
    @(posedge clk_i); #1; flush_i = 1'b0;
    @(negedge clk_i);
    check_eq("flush_kill_out", obs_word(), 64'd0);
    @(posedge clk_i); @(negedge clk_i);
    check_eq("flush_kill_s1", obs_word(), 64'd0);
    @(posedge clk_i); #1; drive_op(vecs[10]);
    @(posedge clk_i); #1; idle();
    @(posedge clk_i); @(negedge clk_i);
    check_eq("flush_recover", obs_word(), want(vecs[10]));

    // Asynchronous reset mid-operation
    @(posedge clk_i); #1; drive_op(vecs[13]);
    @(posedge clk_i); #1; idle();
    @(posedge clk_i); @(negedge clk_i);
    check_eq("arst_pre", obs_word(), want(vecs[13]));
    #2;
    rstn_i = 1'b0;
    #1;
    check_eq("arst_async", obs_word(), 64'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    check_eq("arst_after", obs_word(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lagarto_fp_mult_norm_round.md
Name: lagarto_fp_mult_norm_round

Overview:
- Downstream neighbour of the FP mantissa multiplier.
- Consumes the 2*MANTISSA-bit mantissa product plus the precomputed sign and exponent.
- Normalizes, rounds per RISC-V rounding mode, and produces the packed-ready sign, exponent and fraction, together with overflow/underflow/inexact flags.
- Two-stage pipeline with the same lock/flush semantics as the rest of the FPU datapath.

Parameters:
MANTISSA, 53, significand width including hidden bit (24 for single precision)
EXPONENT, 11, exponent field width (8 for single precision)

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
lock_i  in  1  stall; hold all pipeline registers
flush_i  in  1  kill all in-flight ops
op_valid_i  in  1  input operation valid
product_i  in  2*MANTISSA  unsigned mantissa product
exp_i  in  EXPONENT+2  signed two's complement biased exponent (expA+expB-bias)
sign_i  in  1  result sign
rm_i  in  3  rounding mode
result_valid_o  out  1  result valid
sign_o  out  1  result sign
exp_o  out  EXPONENT  biased exponent field
mant_o  out  MANTISSA-1  fraction field (hidden bit dropped)
overflow_o  out  1  overflow flag
underflow_o  out  1  underflow flag
inexact_o  out  1  inexact flag

Behaviour:
- Reset: all stage registers cleared; every output reads 0.
- Register priority, per stage: reset > flush_i (valid and data cleared) > lock_i (hold) > advance.
- Latency: 2 cycles from op_valid_i to result_valid_o. Throughput: 1 op/cycle.
- Valid gating: all data and flag outputs are forced to 0 when result_valid_o=0.
- Stage 1, normalize:
  - product[2M-1]=1: shift right 1, exp+1.
  - Else if product[2M-2]=1: no shift.
  - Else if product != 0: shift left by (LZC-1), exp -= (LZC-1).
  - If the resulting exp <= 0: shift right by (1-exp), OR-ing shifted-out bits into sticky; exp=0. Shift amount saturates at 2M+1 (all bits become sticky).
  - Zero product: exp=0, mantissa=0, sticky=0; no flags in stage 2.
- Stage 2, round:
  - Keep the top M bits. guard = next bit; sticky = OR of the remaining bits and the stage-1 sticky.
  - rm 000 RNE: increment if guard & (sticky | lsb).
  - rm 001 RTZ: never increment.
  - rm 010 RDN: increment if sign & (guard|sticky).
  - rm 011 RUP: increment if ~sign & (guard|sticky).
  - rm 100 RMM: increment if guard.
  - rm 101–111: treated as RNE.
  - Carry out of M bits: mantissa = 1000..0, exp+1.
  - Subnormal whose hidden bit becomes 1 after rounding: exp=1.
- Overflow (exp >= 2^E-1):
  - overflow=inexact=1.
  - Result is inf (exp all ones, mant 0) for RNE/RMM, RUP with sign 0, and RDN with sign 1.
  - Otherwise max finite (exp 2^E-2, mant all ones).
- inexact = guard|sticky|overflow.
- underflow = (exp field 0 before rounding) & inexact.

Optional Feature:
- Macro: LAGARTO_FP_NR_ONE_STAGE_EN.
- Defined: stage-1 register removed; normalize and round are computed combinationally into a single register; latency 1 cycle. Lock/flush apply to that register.
- Undefined: two-stage, latency 2 as above.

Test Plan:
- M=24,E=8: product 0x900000000000, exp_i=127, sign 0, RNE -> after 2 cycles valid=1, exp_o=128, mant_o=0x100000, flags 0.
- product 0x400000400000, exp_i=100: RNE -> mant_o=0x000000, inexact=1; RUP sign 0 -> mant_o=0x000001; RMM -> 0x000001; RDN sign 0 -> 0x000000.
- product 0x7FFFFFC00000, exp_i=100, RNE -> rounding carry: mant_o=0x000000, exp_o=101, inexact=1.
- product 0x900000000000, exp_i=254: RNE -> exp_o=0xFF, mant_o=0, overflow=inexact=1; RTZ -> exp_o=0xFE, mant_o=0x7FFFFF.
- product 0x400000000000, exp_i=-2 -> exp_o=0, mant_o=0x100000, underflow=0, inexact=0. product 0x400000000001, exp_i=-2 -> underflow=inexact=1.
- Pipeline control:
  - lock_i held for 3 cycles with 2 ops in flight -> outputs frozen, both ops emerge unchanged and in order after release.
  - flush_i for 1 cycle -> result_valid_o=0 for both in-flight slots.
  - rstn_i low mid-operation -> all outputs 0 asynchronously.
